// File: rtl/ns_pkt_generator.sv
// ns_pkt_generator: emits N fixed-size packets of a selected type onto a
// 512-bit AXI-Stream toward the CMAC tx port. Each packet is one header beat
// followed by counting payload beats, with optional idle cycles between packets.
// Optional feature: define NS_PKTGEN_SEQNUM_EN to carry a 32-bit running
// sequence number in header bytes 0-3 (otherwise those bytes are zero).
module ns_pkt_generator #(
  parameter int unsigned DW         = 512,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [1:0]      cmd_type,
  input  logic [31:0]     cmd_count,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  output logic [DW-1:0]   axis_tx_tdata,
  output logic [DW/8-1:0] axis_tx_tkeep,
  output logic            axis_tx_tlast,
  output logic            axis_tx_tvalid,
  input  logic            axis_tx_tready,
  output logic            busy,
  output logic            done
);

  localparam int unsigned KW     = DW / 8;
  localparam int unsigned NWORDS = DW / 32;
  localparam int unsigned BIDX_W = 7;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [BIDX_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic                tvalid_q, tvalid_d;
  logic [DW-1:0]       tdata_q, tdata_d;
  logic [KW-1:0]       tkeep_q, tkeep_d;
  logic                tlast_q, tlast_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                start_pkt, finish_cmd, clear_beat;
  logic [31:0]         hdr_seq;
`ifdef NS_PKTGEN_SEQNUM_EN
  logic [31:0]         seq_q, seq_d;
`endif

  // Index of the final beat of a packet (header is beat 0)
  function automatic logic [BIDX_W-1:0] last_idx(input logic [1:0] t);
    case (t)
      2'd0:    return BIDX_W'(64);
      2'd1:    return BIDX_W'(2);
      default: return BIDX_W'(1);
    endcase
  endfunction

  // Byte enables of the final beat; only the short packet types are partial
  function automatic logic [KW-1:0] last_keep(input logic [1:0] t);
    logic [KW-1:0] k;
    k = '0;
    case (t)
      2'd2:    k[3:0]  = '1;
      2'd3:    k[35:0] = '1;
      default: k       = '1;
    endcase
    return k;
  endfunction

  // Header beat: little-endian sequence in bytes 0-3, type in byte 4
  function automatic logic [DW-1:0] hdr_beat(input logic [31:0] seq, input logic [1:0] t);
    logic [DW-1:0] d;
    d        = '0;
    d[31:0]  = seq;
    d[39:32] = 8'(t);
    return d;
  endfunction

  // Payload beat n: every 32-bit word carries n
  function automatic logic [DW-1:0] pay_beat(input logic [BIDX_W-1:0] n);
    return {NWORDS{32'(n)}};
  endfunction

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    rem_d       = rem_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_pkt   = 1'b0;
    finish_cmd  = 1'b0;
    clear_beat  = 1'b0;
    hdr_seq     = 32'd0;
`ifdef NS_PKTGEN_SEQNUM_EN
    seq_d       = seq_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          type_d = cmd_type;
          rem_d  = cmd_count;
          if (cmd_count == CNT_W'(0)) done_d = 1'b1;
          else                        start_pkt = 1'b1;
        end
      end
      S_HEADER, S_PAYLOAD: begin
        if (tvalid_q && axis_tx_tready) begin
          if (tlast_q) begin
            rem_d = rem_q - CNT_W'(1);
`ifdef NS_PKTGEN_SEQNUM_EN
            seq_d = seq_q + 32'd1;
`endif
            if (GAP_CYCLES != 0) begin
              state_d    = S_GAP;
              gap_d      = CNT_W'(GAP_CYCLES - 1);
              clear_beat = 1'b1;
            end else if (rem_d != CNT_W'(0)) begin
              start_pkt = 1'b1;
            end else begin
              finish_cmd = 1'b1;
            end
          end else begin
            state_d = S_PAYLOAD;
            beat_d  = beat_q + BIDX_W'(1);
            tdata_d = pay_beat(beat_d);
            tlast_d = (beat_d == last_idx(type_q));
            tkeep_d = tlast_d ? last_keep(type_q) : '1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == CNT_W'(0)) begin
          if (rem_q != CNT_W'(0)) start_pkt  = 1'b1;
          else                    finish_cmd = 1'b1;
        end else begin
          gap_d = gap_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef NS_PKTGEN_SEQNUM_EN
    hdr_seq = seq_d;
`endif

    if (start_pkt) begin
      state_d  = S_HEADER;
      beat_d   = '0;
      tvalid_d = 1'b1;
      tdata_d  = hdr_beat(hdr_seq, type_d);
      tkeep_d  = '1;
      tlast_d  = 1'b0;
      busy_d   = 1'b1;
    end

    if (finish_cmd) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      clear_beat = 1'b1;
    end

    if (clear_beat) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      type_q      <= '0;
      rem_q       <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
`ifdef NS_PKTGEN_SEQNUM_EN
      seq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      rem_q       <= rem_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef NS_PKTGEN_SEQNUM_EN
      seq_q       <= seq_d;
`endif
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign axis_tx_tdata  = tdata_q;
  assign axis_tx_tkeep  = tkeep_q;
  assign axis_tx_tlast  = tlast_q;
  assign axis_tx_tvalid = tvalid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
